// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter
//
// Purpose: owns the single register-file write port and shares it between
// the ALU and the load/store unit using a valid/ready handshake with
// round-robin arbitration. Also keeps a per-register pending bit (set by
// the issue stage, cleared when the producing write is granted) and answers
// busy queries for the two issue-stage source operands.
//
// Handshake: a transfer happens in any cycle where valid && ready. ready is
// combinational from the two valid inputs and the round-robin pointer only;
// a requester holds addr/data stable while valid && !ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   alu_valid/ready/addr/data ALU writeback request and grant
//   lsu_valid/ready/addr/data LSU writeback request and grant
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
//   alloc_valid/alloc_addr   issue stage marks a destination pending
//   query_addr1/2, busy1/2   source operand pending lookups
//   alloc_conflict           sticky: allocation to an already-pending register
module rf_writeback_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              alloc_valid,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  logic [ADDR_W-1:0] query_addr1,
    input  logic [ADDR_W-1:0] query_addr2,
    output logic              busy1,
    output logic              busy2,
    output logic              alloc_conflict
);

    // Round-robin pointer: 0 names the ALU, 1 names the LSU.
    logic                r_ptr;
    logic [NUM_REGS-1:0] r_pending;

    logic                w_alu_gnt;
    logic                w_lsu_gnt;
    logic                w_gnt;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;
    logic                w_wr;
    logic                w_alloc;
    logic [NUM_REGS-1:0] w_pending_next;

    // The pointer only matters when both request at once.
    assign w_alu_gnt = alu_valid && (!lsu_valid || !r_ptr);
    assign w_lsu_gnt = lsu_valid && (!alu_valid ||  r_ptr);
    assign w_gnt     = w_alu_gnt || w_lsu_gnt;
    assign w_addr    = w_alu_gnt ? alu_addr : lsu_addr;
    assign w_data    = w_alu_gnt ? alu_data : lsu_data;

    assign alu_ready = w_alu_gnt;
    assign lsu_ready = w_lsu_gnt;

    // Register 0 is hardwired: its transfers are consumed but never written
    // and it is never tracked as pending.
    assign w_wr    = w_gnt && (w_addr != '0);
    assign w_alloc = alloc_valid && (alloc_addr != '0);

    // Clear for the committing write first, then set for the allocation, so
    // a same-cycle allocation to the same register (new producer) wins.
    always_comb begin
        w_pending_next = r_pending;
        if (w_wr) begin
            w_pending_next[w_addr] = 1'b0;
        end
        if (w_alloc) begin
            w_pending_next[alloc_addr] = 1'b1;
        end
    end

    // No bypass: busy reflects the registered bits, so it drops the cycle
    // after the grant, together with the register-file write.
    assign busy1 = (query_addr1 != '0) && r_pending[query_addr1];
    assign busy2 = (query_addr2 != '0) && r_pending[query_addr2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_we          <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            r_ptr          <= 1'b0;
            r_pending      <= '0;
            alloc_conflict <= 1'b0;
        end else begin
            rf_we <= w_wr;
            // Address/data only move on a real write; otherwise they hold.
            if (w_wr) begin
                rf_waddr <= w_addr;
                rf_wdata <= w_data;
            end
            // Contended grant always goes to the pointer; hand priority over.
            if (alu_valid && lsu_valid) begin
                r_ptr <= ~r_ptr;
            end
            if (w_alloc && r_pending[alloc_addr]) begin
                alloc_conflict <= 1'b1;
            end
            r_pending <= w_pending_next;
        end
    end

endmodule
